pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameters: BALL_SPEED, default 2, ball pixels per frame per axis; PAD_SPEED, default 4, paddle pixels per frame; SERVE_FRAMES, default 60, serve delay; WIN_SCORE, default 7, points to win.
REQ-002 SHALL have ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- h_cnt  in  10  VGA horizontal counter.
- v_cnt  in  10  VGA vertical counter.
- BouncingObject  in  1  pixel_gen flag: border or paddle at current pixel.
- start  in  1  level; starts a match.
- up1, down1, up2, down2  in  1 each  paddle buttons, pre-debounced.
- ballX, ballY  out  10 each  ball top-left.
- posY1, posY2  out  9 each  paddle offsets; paddle drawn on rows posY+8..posY+48.
- score1, score2  out  4 each  player scores.
- game_over  out  1  high in GAMEOVER.

Function
REQ-003 SHALL generate a one-clk frame_tick on the 0->1 transition of (v_cnt==480), using a registered copy of that compare; frame_tick fires once per frame at any clk/pixel-clock ratio.
REQ-004 SHALL implement states IDLE, SERVE, PLAY, POINT, GAMEOVER, advancing only on frame_tick, except as in REQ-005.
REQ-005 IDLE or GAMEOVER with start=1: next clk -> SERVE; scores cleared; serve frame counter cleared.
REQ-006 SERVE: ball held at (312,232); frame counter increments per frame_tick; at SERVE_FRAMES ticks -> PLAY, dirX toward the player who lost the last point (first serve: toward player 2, +X), dirY = +Y.
REQ-007 During PLAY, SHALL latch four collision flags when BouncingObject=1 at probe pixels: L (ballX, ballY+8); R (ballX+15, ballY+8); T (ballX+8, ballY); B (ballX+8, ballY+15).
REQ-008 On frame_tick in PLAY: L sets dirX=+, R sets dirX=-, T sets dirY=+, B sets dirY=-; if L and R both set, dirX unchanged; if T and B both set, dirY unchanged; flags then clear.
REQ-009 After direction update on the same tick, ballX/ballY SHALL move BALL_SPEED in dirX/dirY, 10-bit arithmetic, clamped to X 0..624 and Y 8..456, no wrap.
REQ-010 Scoring has priority over collision: on a PLAY tick, if ballX<=BALL_SPEED and dirX=-, score2++; if ballX>=624-BALL_SPEED and dirX=+, score1++; either -> POINT, ball not moved.
REQ-011 POINT lasts one frame: -> GAMEOVER if a score equals WIN_SCORE, else -> SERVE with counter cleared.
REQ-012 Scores saturate at WIN_SCORE and never wrap.
REQ-013 Paddles move on every frame_tick in all states except GAMEOVER: up -> posY-PAD_SPEED, down -> posY+PAD_SPEED, both or neither -> hold; clamped to 0..423.
REQ-014 All outputs SHALL be registered and change only on the clk edge after frame_tick, except score/state reset in REQ-005; values stay stable through active video.
REQ-015 game_over = (state==GAMEOVER); ball held where it stopped in GAMEOVER.

Reset
REQ-016 rst=1 SHALL asynchronously force: state IDLE, ballX=312, ballY=232, posY1=posY2=212, score1=score2=0, dirX=+, dirY=+, collision flags 0, frame counter 0, frame_tick register 0, game_over=0.
REQ-017 Reset asserted mid-frame or mid-rally SHALL take effect immediately; the first frame_tick after release is detected normally.

Structure
REQ-018 Shared package pong_pkg SHALL hold: state enum, field constants (640, 480, border 8), ball size 16, paddle height 41, serve coordinates, paddle clamp 423.
REQ-019 Paddle motion SHALL be sub-module pong_paddle_ctrl (clk, rst, frame_tick, up, down, enable -> pos[8:0]), instantiated twice.

Verification
REQ-020 Reset mid-PLAY at ballX=400 -> all outputs return to REQ-016 values same cycle; IDLE until start.
REQ-021 start, 60 frame_ticks -> PLAY; next tick ballX=314, ballY=234.
REQ-022 Force BouncingObject at probe B with dirY=+ -> after tick dirY=-, ballY decreases by 2; L and R both hit -> dirX unchanged.
REQ-023 Ball at ballX=2, dirX=- on tick -> score2=1, POINT, then SERVE, next serve dirX=-.
REQ-024 up1 and down1 held, both then up1 for 200 frames -> posY1 unchanged, then clamps at 0; down2 held -> posY2 clamps at 423.
REQ-025 score1=6, player 1 scores -> score1=7, GAMEOVER, game_over=1, paddles frozen; start -> scores 0, SERVE.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared state encoding and playfield geometry for the pong
//               game controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    localparam int c_field_w   = 640;
    localparam int c_field_h   = 480;
    localparam int c_border    = 8;
    localparam int c_ball_size = 16;
    localparam int c_pad_h     = 41;

    localparam logic [9:0] c_serve_x    = 10'd312;
    localparam logic [9:0] c_serve_y    = 10'd232;
    localparam logic [9:0] c_ball_x_max = 10'(c_field_w - c_ball_size);
    localparam logic [9:0] c_ball_y_min = 10'(c_border);
    localparam logic [9:0] c_ball_y_max = 10'(c_field_h - c_border - c_ball_size);

    // Paddle offset range keeps the whole paddle between the two borders.
    localparam logic [8:0] c_pad_max  = 9'(c_field_h - 2 * c_border - c_pad_h);
    localparam logic [8:0] c_pad_init = 9'd212;

endpackage
`default_nettype wire

// File: rtl/pong_paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_paddle_ctrl
// Description : One paddle; steps up/down once per frame, clamped to field.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int PAD_SPEED = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       up,
    input  logic       down,
    input  logic       enable,
    output logic [8:0] pos
);

    localparam logic [8:0] c_step = 9'(PAD_SPEED);

    logic [8:0] w_pos_next;

    always_comb begin
        w_pos_next = pos;
        if (frame_tick && enable) begin
            if (up && !down) begin
                w_pos_next = (pos < c_step) ? 9'd0 : pos - c_step;
            end else if (down && !up) begin
                w_pos_next = (pos > c_pad_max - c_step) ? c_pad_max : pos + c_step;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= c_pad_init;
        end else begin
            pos <= w_pos_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Pong match FSM: serve, ball motion, collision, scoring.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALL_SPEED   = 2,
    parameter int PAD_SPEED    = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       BouncingObject,
    input  logic       start,
    input  logic       up1,
    input  logic       down1,
    input  logic       up2,
    input  logic       down2,
    output logic [9:0] ballX,
    output logic [9:0] ballY,
    output logic [8:0] posY1,
    output logic [8:0] posY2,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over
);

    localparam int               c_cnt_w      = $clog2(SERVE_FRAMES + 1);
    localparam logic [c_cnt_w-1:0] c_serve_last = c_cnt_w'(SERVE_FRAMES - 1);
    localparam logic [9:0]       c_bs         = 10'(BALL_SPEED);
    localparam logic [3:0]       c_win        = 4'(WIN_SCORE);

    state_t               r_state, w_state_nx;
    logic                 r_v480;
    logic                 r_dir_x, r_dir_y, r_serve_dir;
    logic                 r_hit_l, r_hit_r, r_hit_t, r_hit_b;
    logic [c_cnt_w-1:0]   r_frame_cnt;

    logic                 w_frame_tick;
    logic                 w_dir_x_nx, w_dir_y_nx, w_serve_dir_nx;
    logic                 w_hit_l_nx, w_hit_r_nx, w_hit_t_nx, w_hit_b_nx;
    logic [c_cnt_w-1:0]   w_frame_cnt_nx;
    logic [9:0]           w_ball_x_nx, w_ball_y_nx;
    logic [3:0]           w_score1_nx, w_score2_nx;
    logic [10:0]          w_x_inc, w_y_inc;

    // Edge of the compare, not the level, so slow pixel clocks still give one tick.
    assign w_frame_tick = (v_cnt == 10'd480) && !r_v480;
    assign w_x_inc      = {1'b0, ballX} + {1'b0, c_bs};
    assign w_y_inc      = {1'b0, ballY} + {1'b0, c_bs};

    always_comb begin
        w_state_nx     = r_state;
        w_dir_x_nx     = r_dir_x;
        w_dir_y_nx     = r_dir_y;
        w_serve_dir_nx = r_serve_dir;
        w_hit_l_nx     = r_hit_l;
        w_hit_r_nx     = r_hit_r;
        w_hit_t_nx     = r_hit_t;
        w_hit_b_nx     = r_hit_b;
        w_frame_cnt_nx = r_frame_cnt;
        w_ball_x_nx    = ballX;
        w_ball_y_nx    = ballY;
        w_score1_nx    = score1;
        w_score2_nx    = score2;

        if (w_frame_tick) begin
            w_hit_l_nx = 1'b0;
            w_hit_r_nx = 1'b0;
            w_hit_t_nx = 1'b0;
            w_hit_b_nx = 1'b0;
        end else if (r_state == ST_PLAY && BouncingObject) begin
            if (h_cnt == ballX          && v_cnt == ballY + 10'd8)  w_hit_l_nx = 1'b1;
            if (h_cnt == ballX + 10'd15 && v_cnt == ballY + 10'd8)  w_hit_r_nx = 1'b1;
            if (h_cnt == ballX + 10'd8  && v_cnt == ballY)          w_hit_t_nx = 1'b1;
            if (h_cnt == ballX + 10'd8  && v_cnt == ballY + 10'd15) w_hit_b_nx = 1'b1;
        end

        case (r_state)
            ST_IDLE, ST_GAMEOVER: begin
                if (start) begin
                    w_state_nx     = ST_SERVE;
                    w_score1_nx    = 4'd0;
                    w_score2_nx    = 4'd0;
                    w_frame_cnt_nx = '0;
                end
            end
            ST_SERVE: begin
                if (w_frame_tick) begin
                    w_ball_x_nx = c_serve_x;
                    w_ball_y_nx = c_serve_y;
                    if (r_frame_cnt == c_serve_last) begin
                        w_state_nx = ST_PLAY;
                        w_dir_x_nx = r_serve_dir;
                        w_dir_y_nx = 1'b1;
                    end else begin
                        w_frame_cnt_nx = r_frame_cnt + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (w_frame_tick) begin
                    if (ballX <= c_bs && !r_dir_x) begin
                        w_state_nx     = ST_POINT;
                        w_serve_dir_nx = 1'b0;
                        if (score2 < c_win) w_score2_nx = score2 + 4'd1;
                    end else if (ballX >= c_ball_x_max - c_bs && r_dir_x) begin
                        w_state_nx     = ST_POINT;
                        w_serve_dir_nx = 1'b1;
                        if (score1 < c_win) w_score1_nx = score1 + 4'd1;
                    end else begin
                        if (r_hit_l != r_hit_r) w_dir_x_nx = r_hit_l;
                        if (r_hit_t != r_hit_b) w_dir_y_nx = r_hit_t;
                        if (w_dir_x_nx) begin
                            w_ball_x_nx = (w_x_inc > {1'b0, c_ball_x_max}) ? c_ball_x_max : w_x_inc[9:0];
                        end else begin
                            w_ball_x_nx = (ballX < c_bs) ? 10'd0 : ballX - c_bs;
                        end
                        if (w_dir_y_nx) begin
                            w_ball_y_nx = (w_y_inc > {1'b0, c_ball_y_max}) ? c_ball_y_max : w_y_inc[9:0];
                        end else begin
                            w_ball_y_nx = (ballY < c_ball_y_min + c_bs) ? c_ball_y_min : ballY - c_bs;
                        end
                    end
                end
            end
            ST_POINT: begin
                if (w_frame_tick) begin
                    if (score1 == c_win || score2 == c_win) begin
                        w_state_nx = ST_GAMEOVER;
                    end else begin
                        w_state_nx     = ST_SERVE;
                        w_frame_cnt_nx = '0;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_v480      <= 1'b0;
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_serve_dir <= 1'b1;
            r_hit_l     <= 1'b0;
            r_hit_r     <= 1'b0;
            r_hit_t     <= 1'b0;
            r_hit_b     <= 1'b0;
            r_frame_cnt <= '0;
            ballX       <= c_serve_x;
            ballY       <= c_serve_y;
            score1      <= 4'd0;
            score2      <= 4'd0;
            game_over   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_v480      <= (v_cnt == 10'd480);
            r_dir_x     <= w_dir_x_nx;
            r_dir_y     <= w_dir_y_nx;
            r_serve_dir <= w_serve_dir_nx;
            r_hit_l     <= w_hit_l_nx;
            r_hit_r     <= w_hit_r_nx;
            r_hit_t     <= w_hit_t_nx;
            r_hit_b     <= w_hit_b_nx;
            r_frame_cnt <= w_frame_cnt_nx;
            ballX       <= w_ball_x_nx;
            ballY       <= w_ball_y_nx;
            score1      <= w_score1_nx;
            score2      <= w_score2_nx;
            game_over   <= (w_state_nx == ST_GAMEOVER);
        end
    end

    pong_paddle_ctrl #(.PAD_SPEED(PAD_SPEED)) u_paddle1 (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (w_frame_tick),
        .up         (up1),
        .down       (down1),
        .enable     (r_state != ST_GAMEOVER),
        .pos        (posY1)
    );

    pong_paddle_ctrl #(.PAD_SPEED(PAD_SPEED)) u_paddle2 (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (w_frame_tick),
        .up         (up2),
        .down       (down2),
        .enable     (r_state != ST_GAMEOVER),
        .pos        (posY2)
    );

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Directed scoreboard bench for pong_game_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] h_cnt = '0;
    logic [9:0] v_cnt = '0;
    logic       BouncingObject = 1'b0;
    logic       start = 1'b0;
    logic       up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0;
    logic [9:0] ballX, ballY;
    logic [8:0] posY1, posY2;
    logic [3:0] score1, score2;
    logic       game_over;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string tag;
        int    sig;
        int    exp;
    } exp_t;
    exp_t sb[$];

    localparam int S_BX = 0, S_BY = 1, S_P1 = 2, S_P2 = 3, S_S1 = 4, S_S2 = 5, S_GO = 6;

    pong_game_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .h_cnt          (h_cnt),
        .v_cnt          (v_cnt),
        .BouncingObject (BouncingObject),
        .start          (start),
        .up1            (up1),
        .down1          (down1),
        .up2            (up2),
        .down2          (down2),
        .ballX          (ballX),
        .ballY          (ballY),
        .posY1          (posY1),
        .posY2          (posY2),
        .score1         (score1),
        .score2         (score2),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    function automatic int get_obs(int sig);
        case (sig)
            S_BX:    return int'(ballX);
            S_BY:    return int'(ballY);
            S_P1:    return int'(posY1);
            S_P2:    return int'(posY2);
            S_S1:    return int'(score1);
            S_S2:    return int'(score2);
            S_GO:    return int'(game_over);
            default: return -1;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sig, input int exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        int   obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = get_obs(e.sig);
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk) v_cnt = 10'd480;
        @(negedge clk) v_cnt = 10'd0;
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic hit(input logic [9:0] h, input logic [9:0] v);
        @(negedge clk) begin h_cnt = h; v_cnt = v; BouncingObject = 1'b1; end
        @(negedge clk) begin h_cnt = '0; v_cnt = '0; BouncingObject = 1'b0; end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        expect_val("rst_bx", S_BX, 312);
        expect_val("rst_by", S_BY, 232);
        expect_val("rst_p1", S_P1, 212);
        expect_val("rst_p2", S_P2, 212);
        expect_val("rst_s1", S_S1, 0);
        expect_val("rst_s2", S_S2, 0);
        expect_val("rst_go", S_GO, 0);
        check_all();

        // Paddles in IDLE: both buttons hold, then clamps at each end.
        up1 = 1'b1; down1 = 1'b1; down2 = 1'b1;
        frames(10);
        expect_val("pad_both_hold", S_P1, 212);
        expect_val("pad2_down10", S_P2, 252);
        check_all();
        down1 = 1'b0;
        frames(200);
        expect_val("pad1_clamp0", S_P1, 0);
        expect_val("pad2_clamp423", S_P2, 423);
        check_all();
        up1 = 1'b0; down2 = 1'b0;

        // Serve and first move.
        pulse_start();
        frames(60);
        expect_val("serve_bx", S_BX, 312);
        expect_val("serve_by", S_BY, 232);
        check_all();
        tick();
        expect_val("play1_bx", S_BX, 314);
        expect_val("play1_by", S_BY, 234);
        check_all();

        // Bottom probe flips dirY.
        hit(10'd322, 10'd249);
        tick();
        expect_val("bot_bx", S_BX, 316);
        expect_val("bot_by", S_BY, 232);
        check_all();
        // Left and right together leave dirX alone.
        hit(10'd316, 10'd240);
        hit(10'd331, 10'd240);
        tick();
        expect_val("lr_bx", S_BX, 318);
        expect_val("lr_by", S_BY, 230);
        check_all();
        // Right alone sends ball left.
        hit(10'd333, 10'd238);
        tick();
        expect_val("r_bx", S_BX, 316);
        expect_val("r_by", S_BY, 228);
        check_all();

        // Travel to the left edge; Y clamps at the top border.
        frames(157);
        expect_val("edge_bx", S_BX, 2);
        expect_val("edge_by", S_BY, 8);
        check_all();
        tick();
        expect_val("pt2_s2", S_S2, 1);
        expect_val("pt2_s1", S_S1, 0);
        expect_val("pt2_bx_hold", S_BX, 2);
        check_all();
        frames(61);
        expect_val("reserve_bx", S_BX, 312);
        check_all();
        tick();
        expect_val("reserve_dir_bx", S_BX, 310);
        expect_val("reserve_dir_by", S_BY, 234);
        check_all();

        // Left probe sends ball right, then player 1 wins every rally.
        hit(10'd310, 10'd242);
        tick();
        expect_val("l_bx", S_BX, 312);
        expect_val("l_by", S_BY, 236);
        check_all();
        for (int k = 1; k <= 7; k++) begin
            int n;
            n = 0;
            while (score1 != 4'(k) && n < 600) begin
                tick();
                n++;
            end
            expect_val("rally_s1", S_S1, k);
            expect_val("rally_bx", S_BX, 622);
            check_all();
        end
        tick();
        expect_val("go_flag", S_GO, 1);
        expect_val("go_s1", S_S1, 7);
        expect_val("go_s2", S_S2, 1);
        check_all();
        down1 = 1'b1; up2 = 1'b1;
        frames(5);
        expect_val("go_p1_frozen", S_P1, 0);
        expect_val("go_p2_frozen", S_P2, 423);
        expect_val("go_bx_hold", S_BX, 622);
        expect_val("go_s1_sat", S_S1, 7);
        check_all();
        down1 = 1'b0; up2 = 1'b0;

        // Restart clears scores immediately.
        pulse_start();
        expect_val("restart_s1", S_S1, 0);
        expect_val("restart_s2", S_S2, 0);
        expect_val("restart_go", S_GO, 0);
        check_all();

        // Mid-rally asynchronous reset.
        frames(60 + 44);
        expect_val("pre_rst_bx", S_BX, 400);
        check_all();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        expect_val("arst_bx", S_BX, 312);
        expect_val("arst_by", S_BY, 232);
        expect_val("arst_p1", S_P1, 212);
        expect_val("arst_p2", S_P2, 212);
        expect_val("arst_s1", S_S1, 0);
        expect_val("arst_s2", S_S2, 0);
        expect_val("arst_go", S_GO, 0);
        check_all();
        @(negedge clk) rst = 1'b0;
        frames(3);
        expect_val("idle_bx", S_BX, 312);
        expect_val("idle_by", S_BY, 232);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
